// File: rtl/spi_arbiter.sv
// Two-requester SPI frame arbiter: round-robin grant, one transfer in flight,
// per-requester receive/timeout results, and a saturating transfer watchdog.
module spi_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned DW      = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] tx0,
  input  logic [DW-1:0] tx1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rx0,
  output logic [DW-1:0] rx1,
  output logic          err0,
  output logic          err1,
  output logic          spi_start,
  output logic [DW-1:0] spi_txdata,
  input  logic          spi_busy,
  input  logic [DW-1:0] spi_rxdata,
  output logic          arb_busy
);

  localparam int unsigned    CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic          owner;
  logic          last;
  logic [CW-1:0] cnt;
  logic [DW-1:0] rx0_q, rx1_q;
  logic          err0_q, err1_q;
  logic          grant, grant_sel;
  logic          ok, tmo, finish;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = 1'b0;
    ok        = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (!HRESET && (req0 || req1)) begin
          grant     = 1'b1;
          grant_sel = req1 & (!req0 | !last);
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (cnt == CNT_LIMIT) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else if (spi_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // a frame that completes on the limit cycle still counts as success
        if (!spi_busy) begin
          ok        = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LIMIT) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign finish    = ok | tmo;
  assign gnt0      = grant & !grant_sel;
  assign gnt1      = grant & grant_sel;
  assign done0     = finish & !owner;
  assign done1     = finish & owner;
  assign spi_start = (state == START);
  assign arb_busy  = (state != IDLE) | grant;

  // results are forwarded during the done cycle so they are valid with the pulse
  assign rx0  = (done0 && ok) ? spi_rxdata : rx0_q;
  assign rx1  = (done1 && ok) ? spi_rxdata : rx1_q;
  assign err0 = done0 ? tmo : err0_q;
  assign err1 = done1 ? tmo : err1_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      spi_txdata <= '0;
      rx0_q      <= '0;
      rx1_q      <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        spi_txdata <= grant_sel ? tx1 : tx0;
        owner      <= grant_sel;
      end
      if (state == START) begin
        cnt <= '0;
      end else if ((state == WAIT_BUSY || state == WAIT_DONE) && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        last <= owner;
        if (owner) begin
          err1_q <= tmo;
          if (ok) rx1_q <= spi_rxdata;
        end else begin
          err0_q <= tmo;
          if (ok) rx0_q <= spi_rxdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a loopback shift-engine model.
module tb_spi_arbiter;

  logic       HCLK, HRESET;
  logic       req0, req1;
  logic [7:0] tx0, tx1;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic [7:0] rx0, rx1;
  logic       spi_start, spi_busy, arb_busy;
  logic [7:0] spi_txdata, spi_rxdata;

  int n_asserts = 0;
  int n_fail    = 0;

  spi_arbiter #(.TIMEOUT(16), .DW(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .req1(req1), .tx0(tx0), .tx1(tx1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rx0(rx0), .rx1(rx1), .err0(err0), .err1(err1),
    .spi_start(spi_start), .spi_txdata(spi_txdata),
    .spi_busy(spi_busy), .spi_rxdata(spi_rxdata), .arb_busy(arb_busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // loopback engine: busy the edge after spi_start, 8 shifts, MISO tied to MOSI
  logic       dead;
  logic [3:0] eng_cnt;
  logic [7:0] tx_sh, rx_sh;
  assign spi_rxdata = rx_sh;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      spi_busy <= 1'b0; eng_cnt <= '0; tx_sh <= '0; rx_sh <= '0;
    end else if (eng_cnt != 0) begin
      tx_sh   <= tx_sh << 1;
      rx_sh   <= {rx_sh[6:0], tx_sh[7]};
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) spi_busy <= 1'b0;
    end else if (spi_start && !dead) begin
      tx_sh    <= spi_txdata;
      eng_cnt  <= 4'd8;
      spi_busy <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return gnt0;
      1:       return gnt1;
      2:       return done0;
      default: return done1;
    endcase
  endfunction

  // counts negedges from the current one until the selected pulse is seen
  task automatic wait_hi(input int sel, input int limit, output int cyc);
    cyc = 0;
    while (!sig(sel) && cyc < limit) begin
      @(negedge HCLK);
      cyc++;
    end
    if (!sig(sel)) check($sformatf("wait_bound_%0d", sel), 32'(sig(sel)), 1);
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
    @(posedge HCLK);
    #1;
    req0 = r0; req1 = r1; tx0 = d0; tx1 = d1;
  endtask

  // global properties: exclusive pulses, start follows grant, frame held in flight
  logic       prev_gnt, prev_busy;
  logic [7:0] prev_txd;
  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_gnt  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      check("gnt_excl", 32'(gnt0 & gnt1), 0);
      check("done_excl", 32'(done0 & done1), 0);
      check("start_after_gnt", 32'(spi_start), 32'(prev_gnt));
      if (prev_busy && arb_busy && !prev_gnt) check("txd_stable", spi_txdata, prev_txd);
      prev_gnt  = gnt0 | gnt1;
      prev_busy = arb_busy;
      prev_txd  = spi_txdata;
    end
  end

  int cyc;

  initial begin
    HRESET = 1'b1; req0 = 1'b0; req1 = 1'b0; tx0 = '0; tx1 = '0; dead = 1'b0;
    #12;
    req0 = 1'b1;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_start", spi_start, 0);
    check("rst_txd", spi_txdata, 0);
    check("rst_rx0", rx0, 0);
    check("rst_err1", err1, 0);
    req0 = 1'b0;
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("idle_busy", arb_busy, 0);
    check("idle_gnt", 32'(gnt0 | gnt1), 0);

    // first tie after reset goes to requester 0, then 1 the cycle after done0
    drive(1, 1, 8'h3C, 8'hA5);
    @(negedge HCLK);
    check("tie1_gnt0", gnt0, 1);
    check("tie1_gnt1", gnt1, 0);
    drive(0, 1, 8'h3C, 8'hA5);
    @(negedge HCLK);
    check("tie1_start", spi_start, 1);
    check("tie1_txd", spi_txdata, 8'h3C);
    wait_hi(2, 40, cyc);
    check("tie1_lat", cyc, 9);
    check("tie1_rx0", rx0, 8'h3C);
    check("tie1_err0", err0, 0);
    @(negedge HCLK);
    check("tie1_gnt1_next", gnt1, 1);
    drive(0, 0, 8'h3C, 8'hA5);
    @(negedge HCLK);
    check("tie1_txd1", spi_txdata, 8'hA5);
    wait_hi(3, 40, cyc);
    check("tie1_rx1", rx1, 8'hA5);
    check("tie1_rx0_hold", rx0, 8'h3C);

    // single loopback frame
    drive(1, 0, 8'h85, 8'h00);
    @(negedge HCLK);
    check("lb_gnt0", gnt0, 1);
    drive(0, 0, 8'h85, 8'h00);
    @(negedge HCLK);
    check("lb_start", spi_start, 1);
    check("lb_txd", spi_txdata, 8'h85);
    wait_hi(2, 40, cyc);
    check("lb_lat", cyc, 9);
    check("lb_rx0", rx0, 8'h85);
    check("lb_err0", err0, 0);
    @(negedge HCLK);
    check("lb_done_once", done0, 0);
    check("lb_idle", arb_busy, 0);
    check("lb_rx0_hold", rx0, 8'h85);

    // requester 0 served last, so this tie goes to requester 1 first
    drive(1, 1, 8'h0F, 8'hF0);
    @(negedge HCLK);
    check("tie2_gnt1", gnt1, 1);
    check("tie2_gnt0", gnt0, 0);
    drive(1, 0, 8'h0F, 8'hF0);
    wait_hi(3, 40, cyc);
    check("tie2_rx1", rx1, 8'hF0);
    @(negedge HCLK);
    check("tie2_gnt0_next", gnt0, 1);
    drive(0, 0, 8'h0F, 8'hF0);
    wait_hi(2, 40, cyc);
    check("tie2_rx0", rx0, 8'h0F);

    // engine never goes busy: abort after 16 cycles, rx1 kept
    dead = 1'b1;
    drive(0, 1, 8'h00, 8'h5A);
    @(negedge HCLK);
    check("to_gnt1", gnt1, 1);
    drive(0, 0, 8'h00, 8'h5A);
    @(negedge HCLK);
    check("to_start", spi_start, 1);
    wait_hi(3, 40, cyc);
    check("to_lat", cyc, 16);
    check("to_err1", err1, 1);
    check("to_rx1", rx1, 8'hF0);
    check("to_rx0", rx0, 8'h0F);
    @(negedge HCLK);
    check("to_err1_hold", err1, 1);
    dead = 1'b0;
    drive(0, 1, 8'h00, 8'h5A);
    @(negedge HCLK);
    check("to2_gnt1", gnt1, 1);
    drive(0, 0, 8'h00, 8'h5A);
    wait_hi(3, 40, cyc);
    check("to2_err1", err1, 0);
    check("to2_rx1", rx1, 8'h5A);

    // req1 arrives mid-transfer: held off until after done0, arb_busy never drops
    drive(1, 0, 8'hC3, 8'h7E);
    @(negedge HCLK);
    check("pend_gnt0", gnt0, 1);
    drive(0, 0, 8'hC3, 8'h7E);
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      check("pend_busy_a", arb_busy, 1);
    end
    drive(0, 1, 8'hC3, 8'h7E);
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      check("pend_busy_b", arb_busy, 1);
      if (done0) break;
      check("pend_no_gnt1", gnt1, 0);
    end
    check("pend_done0", done0, 1);
    check("pend_rx0", rx0, 8'hC3);
    @(negedge HCLK);
    check("pend_gnt1", gnt1, 1);
    check("pend_busy_g", arb_busy, 1);
    drive(0, 0, 8'hC3, 8'h7E);
    for (int k = 0; k < 40; k++) begin
      @(negedge HCLK);
      check("pend_busy_c", arb_busy, 1);
      if (done1) break;
    end
    check("pend_done1", done1, 1);
    check("pend_rx1", rx1, 8'h7E);

    // asynchronous reset in WAIT_DONE
    drive(1, 0, 8'h11, 8'h00);
    @(negedge HCLK);
    check("ar_gnt0", gnt0, 1);
    drive(0, 0, 8'h11, 8'h00);
    repeat (3) @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    check("ar_busy", arb_busy, 0);
    check("ar_start", spi_start, 0);
    check("ar_txd", spi_txdata, 0);
    check("ar_rx0", rx0, 0);
    check("ar_rx1", rx1, 0);
    check("ar_err", 32'({err0, err1}), 0);
    check("ar_done", 32'({done0, done1}), 0);
    repeat (2) begin
      @(negedge HCLK);
      check("ar_no_done", done0, 0);
    end
    @(posedge HCLK); #1 HRESET = 1'b0;
    drive(1, 1, 8'h96, 8'h69);
    @(negedge HCLK);
    check("ar_tie_gnt0", gnt0, 1);
    drive(0, 1, 8'h96, 8'h69);
    wait_hi(2, 40, cyc);
    check("ar_rx0_new", rx0, 8'h96);
    check("ar_err0_new", err0, 0);
    @(negedge HCLK);
    check("ar_gnt1", gnt1, 1);
    drive(0, 0, 8'h96, 8'h69);
    wait_hi(3, 40, cyc);
    check("ar_rx1_new", rx1, 8'h69);

    @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
